exec_stage: RTL

Execute/writeback stage for the 8-register, 8-bit core. It consumes the two combinational read ports of the register file together with a decoded opcode and computes the result. It then drives the register file's write port (`wr_en`, `wr_addr`, `dat_in`) from registered outputs. Single-cycle ALU ops complete in one cycle; MUL is an iterative 8-cycle shift-add that stalls the upstream decoder through `in_ready`.

---
 rtl/exec_pkg.sv | 26 ++
 rtl/exec_mul_iter.sv | 44 ++++
 rtl/exec_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared opcode/state encodings and default widths for the execute/writeback stage.
package exec_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MOV = 4'd8,
        OP_CMP = 4'd9,
        OP_MUL = 4'd10
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one partial product per enabled cycle, DW cycles total.
module mul_iter #(
    parameter int DW = 8,
    parameter int CW = $clog2(DW)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            run,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [CW-1:0]   cnt,
    output logic [2*DW-1:0] product,
    output logic            done
);

    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] addend;

    // product is the post-iteration value so the final sum is usable on the done edge
    assign addend  = b_q[cnt] ? ({{DW{1'b0}}, a_q} << cnt) : '0;
    assign product = acc + addend;
    assign done    = run && (cnt == CW'(DW - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            cnt <= '0;
        end else if (run) begin
            acc <= product;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage: single-cycle ALU plus iterative MUL driving the regfile write port.
// Optional write-data bypass onto the operand ports is enabled by defining EXEC_FWD_EN.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          flag_z,
    output logic          flag_c,
    output logic          busy
);

    localparam int CW = $clog2(DW);

    state_e          state, state_nxt;
    logic            accept;
    logic [DW-1:0]   a_val, b_val;
    logic [DW-1:0]   alu_res;
    logic            alu_c, alu_wr, alu_upd;
    logic [DW:0]     sum, diff, shl_w, shr_w;
    logic [AW-1:0]   mul_dst;
    logic [CW-1:0]   mul_cnt;
    logic [2*DW-1:0] mul_prod;
    logic            mul_done;

    assign in_ready = !reset && (state == IDLE);
    assign busy     = (state == MUL);
    assign accept   = in_valid && in_ready;

`ifdef EXEC_FWD_EN
    // The write in flight has not reached the regfile yet, so take it from our own output.
    assign a_val = (wr_en && (wr_addr == src_a)) ? wr_data : opa;
    assign b_val = (wr_en && (wr_addr == src_b)) ? wr_data : opb;
`else
    logic unused_src;
    assign unused_src = ^{src_a, src_b};
    assign a_val = opa;
    assign b_val = opb;
`endif

    assign sum   = {1'b0, a_val} + {1'b0, b_val};
    assign diff  = {1'b0, a_val} - {1'b0, b_val};
    // extra bit on the shifted-out side captures the last bit lost; zero for shift of 0
    assign shl_w = {1'b0, a_val} << b_val[2:0];
    assign shr_w = {a_val, 1'b0} >> b_val[2:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b0;
        alu_upd = 1'b0;
        case (op)
            OP_ADD: begin alu_res = sum[DW-1:0];    alu_c = sum[DW];   alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_SUB: begin alu_res = diff[DW-1:0];   alu_c = diff[DW];  alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_AND: begin alu_res = a_val & b_val;                     alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_OR:  begin alu_res = a_val | b_val;                     alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_XOR: begin alu_res = a_val ^ b_val;                     alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_SHL: begin alu_res = shl_w[DW-1:0];  alu_c = shl_w[DW]; alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_SHR: begin alu_res = shr_w[DW:1];    alu_c = shr_w[0];  alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_MOV: begin alu_res = b_val;                             alu_wr = 1'b1; alu_upd = 1'b1; end
            OP_CMP: begin alu_res = diff[DW-1:0];   alu_c = diff[DW];                 alu_upd = 1'b1; end
            default: ;
        endcase
    end

    mul_iter #(.DW(DW), .CW(CW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && (op == OP_MUL)),
        .run     (busy),
        .a       (a_val),
        .b       (b_val),
        .cnt     (mul_cnt),
        .product (mul_prod),
        .done    (mul_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (op == OP_MUL)) state_nxt = MUL;
            MUL:     if (mul_cnt == CW'(DW - 1))   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            mul_dst <= '0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                if (alu_wr) begin
                    wr_en   <= 1'b1;
                    wr_addr <= dst;
                    wr_data <= alu_res;
                end
                if (alu_upd) begin
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                end
                if (op == OP_MUL) mul_dst <= dst;
            end
            if (mul_done) begin
                wr_en   <= 1'b1;
                wr_addr <= mul_dst;
                wr_data <= mul_prod[DW-1:0];
                flag_z  <= (mul_prod[DW-1:0] == '0);
                flag_c  <= |mul_prod[2*DW-1:DW];
            end
        end
    end

endmodule
